// File: rtl/alu_issue_if.sv
// alu_issue_if
// Bundles every non-clock signal of the ALU issue unit: the instruction
// handshake, the operand/result path to the clocked ALU, the retire and
// illegal-op strobes, and the register-file debug read port.
//   slave  : the issue unit side (takes instructions, drives the ALU)
//   master : the environment side (instruction source, ALU, debug reader)
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_funct;
    logic [31:0] alu_res;
    logic        out_valid;
    logic [3:0]  out_rd;
    logic [31:0] out_data;
    logic        err_illegal;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    modport slave (
        input  in_valid, in_instr, alu_res, dbg_addr,
        output in_ready, alu_a, alu_b, alu_shamt, alu_funct,
               out_valid, out_rd, out_data, err_illegal, dbg_data
    );

    modport master (
        output in_valid, in_instr, alu_res, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_shamt, alu_funct,
               out_valid, out_rd, out_data, err_illegal, dbg_data
    );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Serial instruction sequencer in front of a clocked ALU. Owns a 16 x 32
// register file, accepts one instruction per valid/ready handshake in IDLE,
// presents operands and a one-cycle function code to the ALU (ISSUE), then
// writes the ALU result (or an LDI immediate) back and strobes out_valid (WB).
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus.slave : in_valid/in_ready/in_instr handshake, alu_a/alu_b/alu_shamt/
//               alu_funct to the ALU, alu_res back, out_valid/out_rd/out_data
//               retire strobe, err_illegal pulse, dbg_addr/dbg_data read port
// Parameter R0_ZERO: when non-zero R0 reads as 0 and writes to it are dropped.
module alu_issue_unit #(
    parameter int unsigned R0_ZERO = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    localparam logic       R0_FORCED = (R0_ZERO != 32'd0);
    localparam logic [3:0] OP_LDI    = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] rf_r      [16];
    logic [31:0] rf_view_s [16];

    // Instruction fields of the incoming word
    logic [3:0]  op_s;
    logic [3:0]  rd_s;
    logic [3:0]  rs_s;
    logic [3:0]  rt_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;

    // Latched instruction state needed at writeback
    logic [3:0]  op_r;
    logic [3:0]  rd_r;
    logic [15:0] imm_r;

    // Registered outputs
    logic        in_ready_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [4:0]  alu_shamt_r;
    logic [3:0]  alu_funct_r;
    logic        out_valid_r;
    logic [3:0]  out_rd_r;
    logic [31:0] out_data_r;
    logic        err_illegal_r;

    // Per-cycle control decisions
    logic        accept_s;
    logic        illegal_s;
    logic        retire_s;
    logic [3:0]  funct_nxt_s;
    logic [31:0] wdata_s;

    // Ops 1..9 go to the ALU, 10 is LDI; 0 and 11..15 are illegal.
    function automatic logic op_legal(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd10);
    endfunction

    assign op_s    = bus.in_instr[31:28];
    assign rd_s    = bus.in_instr[27:24];
    assign rs_s    = bus.in_instr[23:20];
    assign rt_s    = bus.in_instr[19:16];
    assign shamt_s = bus.in_instr[15:11];
    assign imm_s   = bus.in_instr[15:0];

    // Architectural view of the register file with the R0 rule applied
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            rf_view_s[i] = rf_r[i];
        end
        rf_view_s[0] = R0_FORCED ? 32'd0 : rf_r[0];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && op_legal(op_s)) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WB;
            ST_WB:    state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: what the datapath registers do at the coming edge
    always_comb begin
        accept_s    = 1'b0;
        illegal_s   = 1'b0;
        retire_s    = 1'b0;
        funct_nxt_s = 4'd0;
        case (state_r)
            ST_IDLE: begin
                accept_s  = bus.in_valid && op_legal(op_s);
                illegal_s = bus.in_valid && !op_legal(op_s);
                // LDI bypasses the ALU, so its function code stays 0
                if (accept_s && (op_s != OP_LDI)) begin
                    funct_nxt_s = op_s;
                end else begin
                    funct_nxt_s = 4'd0;
                end
            end
            ST_ISSUE: begin
                retire_s = 1'b0;
            end
            ST_WB: begin
                retire_s = 1'b1;
            end
            default: begin
                retire_s = 1'b0;
            end
        endcase
    end

    // Writeback value: LDI immediate or the ALU's registered result
    always_comb begin
        if (op_r == OP_LDI) begin
            wdata_s = {16'd0, imm_r};
        end else begin
            wdata_s = bus.alu_res;
        end
    end

    // Operand/instruction capture and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r    <= 1'b1;
            alu_a_r       <= 32'd0;
            alu_b_r       <= 32'd0;
            alu_shamt_r   <= 5'd0;
            alu_funct_r   <= 4'd0;
            op_r          <= 4'd0;
            rd_r          <= 4'd0;
            imm_r         <= 16'd0;
            out_valid_r   <= 1'b0;
            out_rd_r      <= 4'd0;
            out_data_r    <= 32'd0;
            err_illegal_r <= 1'b0;
        end else begin
            in_ready_r    <= (state_nxt_s == ST_IDLE);
            // Non-zero only for the ISSUE cycle, so the ALU updates exactly once
            alu_funct_r   <= funct_nxt_s;
            err_illegal_r <= illegal_s;
            out_valid_r   <= retire_s;
            if (accept_s) begin
                alu_a_r     <= rf_view_s[rs_s];
                alu_b_r     <= rf_view_s[rt_s];
                alu_shamt_r <= shamt_s;
                op_r        <= op_s;
                rd_r        <= rd_s;
                imm_r       <= imm_s;
            end else begin
                alu_a_r     <= alu_a_r;
                alu_b_r     <= alu_b_r;
                alu_shamt_r <= alu_shamt_r;
                op_r        <= op_r;
                rd_r        <= rd_r;
                imm_r       <= imm_r;
            end
            if (retire_s) begin
                out_rd_r   <= rd_r;
                out_data_r <= wdata_s;
            end else begin
                out_rd_r   <= out_rd_r;
                out_data_r <= out_data_r;
            end
        end
    end

    // Register file write at the WB closing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else begin
            if (retire_s && !(R0_FORCED && (rd_r == 4'd0))) begin
                rf_r[rd_r] <= wdata_s;
            end else begin
                rf_r[rd_r] <= rf_r[rd_r];
            end
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_shamt   = alu_shamt_r;
    assign bus.alu_funct   = alu_funct_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_rd      = out_rd_r;
    assign bus.out_data    = out_data_r;
    assign bus.err_illegal = err_illegal_r;
    assign bus.dbg_data    = rf_view_s[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
// Directed bench for alu_issue_unit with a behavioural clocked ALU attached.
module tb_alu_issue_unit;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    alu_issue_if bus ();

    alu_issue_unit #(.R0_ZERO(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural clocked ALU: registers a result only while funct != 0
    function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        logic [4:0] amt;
        amt = (sh == 5'd0) ? {4'd0, b[0]} : sh;
        case (f)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return ~a;
            4'd7:    return a << amt;
            4'd8:    return $unsigned($signed(a) >>> amt);
            4'd9:    return a >> amt;
            default: return a;
        endcase
    endfunction

    logic [31:0] alu_res_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alu_res_q <= 32'd0;
        else if (bus.alu_funct != 4'd0)
            alu_res_q <= alu_f(bus.alu_funct, bus.alu_a, bus.alu_b, bus.alu_shamt);
    end
    assign bus.alu_res = alu_res_q;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt,
                                        input logic [4:0] sh);
        return {op, rd, rs, rt, sh, 11'd0};
    endfunction

    function automatic logic [31:0] ldi(input logic [3:0] rd, input logic [15:0] imm);
        return {4'd10, rd, 8'd0, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dbg_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        bus.dbg_addr = addr;
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    // Issue one instruction and wait (bounded) for its retire strobe.
    // Returns at the negedge where out_valid is seen.
    task automatic run(input logic [31:0] instr, output int lat,
                       output int fcyc, output logic [3:0] fval);
        lat  = -1;
        fcyc = 0;
        fval = 4'd0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.alu_funct != 4'd0) begin
                fcyc++;
                fval = bus.alu_funct;
            end
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic exec(input string tag, input logic [31:0] instr, input logic [3:0] exp_rd,
                        input logic [31:0] exp_data, input logic [3:0] exp_funct);
        int lat;
        int fcyc;
        logic [3:0] fval;
        run(instr, lat, fcyc, fval);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_rd"}, {28'd0, bus.out_rd}, {28'd0, exp_rd});
        check({tag, "_data"}, bus.out_data, exp_data);
        check({tag, "_funct_val"}, {28'd0, fval}, {28'd0, exp_funct});
        check({tag, "_funct_cycles"}, 32'(fcyc), (exp_funct != 4'd0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #20000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        logic [31:0] prog    [4];
        logic [31:0] exp_d   [4];
        logic [3:0]  exp_r   [4];
        int          ret_cyc [4];
        int          idx;
        int          nret;
        int          cyc;
        logic        acc;
        logic        seen;

        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.dbg_addr = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_err", {31'd0, bus.err_illegal}, 32'd0);
        check("rst_funct", {28'd0, bus.alu_funct}, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        dbg_chk("rst_r5", 4'd5, 32'd0);

        // NOT R1,R0
        exec("not_r1", enc(4'd6, 4'd1, 4'd0, 4'd0, 5'd0), 4'd1, 32'hFFFF_FFFF, 4'd6);
        check("not_err_low", {31'd0, bus.err_illegal}, 32'd0);
        dbg_chk("dbg_r1", 4'd1, 32'hFFFF_FFFF);

        // Back-to-back program under continuous in_valid
        prog[0] = ldi(4'd2, 16'h0005);              exp_r[0] = 4'd2; exp_d[0] = 32'd5;
        prog[1] = ldi(4'd3, 16'h0003);              exp_r[1] = 4'd3; exp_d[1] = 32'd3;
        prog[2] = enc(4'd1, 4'd4, 4'd2, 4'd3, 5'd0); exp_r[2] = 4'd4; exp_d[2] = 32'd8;
        prog[3] = enc(4'd2, 4'd5, 4'd3, 4'd2, 5'd0); exp_r[3] = 4'd5; exp_d[3] = 32'hFFFF_FFFE;
        idx  = 0;
        nret = 0;
        cyc  = 0;
        for (int i = 0; i < 4; i++) ret_cyc[i] = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = prog[0];
        while ((nret < 4) && (cyc < 40)) begin
            acc = bus.in_ready;
            if (bus.out_valid) begin
                check("prog_rd", {28'd0, bus.out_rd}, {28'd0, exp_r[nret]});
                check("prog_data", bus.out_data, exp_d[nret]);
                ret_cyc[nret] = cyc;
                nret++;
            end
            @(posedge clk);
            #1;
            if (acc && (idx < 4)) begin
                idx++;
                if (idx < 4) bus.in_instr = prog[idx];
                else begin
                    bus.in_valid = 1'b0;
                    bus.in_instr = 32'd0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("prog_retires", 32'(nret), 32'd4);
        check("prog_space01", 32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
        check("prog_space12", 32'(ret_cyc[2] - ret_cyc[1]), 32'd3);
        check("prog_space23", 32'(ret_cyc[3] - ret_cyc[2]), 32'd3);
        dbg_chk("dbg_r4", 4'd4, 32'd8);
        dbg_chk("dbg_r5", 4'd5, 32'hFFFF_FFFE);

        // Shifts
        exec("ldi_r6", ldi(4'd6, 16'h8000), 4'd6, 32'h0000_8000, 4'd0);
        exec("sla_r7", enc(4'd7, 4'd7, 4'd6, 4'd0, 5'd16), 4'd7, 32'h8000_0000, 4'd7);
        exec("sra_r8", enc(4'd8, 4'd8, 4'd7, 4'd0, 5'd4), 4'd8, 32'hF800_0000, 4'd8);
        exec("srl_r9", enc(4'd9, 4'd9, 4'd7, 4'd0, 5'd4), 4'd9, 32'h0800_0000, 4'd9);
        dbg_chk("dbg_r7", 4'd7, 32'h8000_0000);
        dbg_chk("dbg_r8", 4'd8, 32'hF800_0000);
        dbg_chk("dbg_r9", 4'd9, 32'h0800_0000);

        // shamt=0 path: shift by R2[0]=1
        exec("srl_sh0", enc(4'd9, 4'd10, 4'd1, 4'd2, 5'd0), 4'd10, 32'h7FFF_FFFF, 4'd9);
        dbg_chk("dbg_r10", 4'd10, 32'h7FFF_FFFF);

        // Illegal op 0 then op 15 back to back, both targeting R4
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = enc(4'd0, 4'd4, 4'd2, 4'd3, 5'd0);
        @(posedge clk);
        #1;
        bus.in_instr = enc(4'd15, 4'd4, 4'd2, 4'd3, 5'd0);
        @(negedge clk);
        check("ill0_err", {31'd0, bus.err_illegal}, 32'd1);
        check("ill0_ready", {31'd0, bus.in_ready}, 32'd1);
        check("ill0_funct", {28'd0, bus.alu_funct}, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        @(negedge clk);
        check("ill15_err", {31'd0, bus.err_illegal}, 32'd1);
        check("ill15_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = seen | bus.out_valid;
            @(negedge clk);
        end
        check("ill_no_out_valid", {31'd0, seen}, 32'd0);
        check("ill_err_clears", {31'd0, bus.err_illegal}, 32'd0);
        dbg_chk("ill_r4_kept", 4'd4, 32'd8);

        // Write to R0 is reported but discarded
        exec("ldi_r0", ldi(4'd0, 16'h1234), 4'd0, 32'h0000_1234, 4'd0);
        dbg_chk("dbg_r0", 4'd0, 32'd0);

        // Reset during ISSUE of ADD R4,R2,R3
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = enc(4'd1, 4'd4, 4'd2, 4'd3, 5'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        @(negedge clk);
        check("mid_issue_funct", {28'd0, bus.alu_funct}, 32'd1);
        check("mid_issue_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid_issue_a", bus.alu_a, 32'd5);
        check("mid_issue_b", bus.alu_b, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check("post_rst_no_out_valid", {31'd0, seen}, 32'd0);
        dbg_chk("post_rst_r1", 4'd1, 32'd0);
        dbg_chk("post_rst_r2", 4'd2, 32'd0);
        dbg_chk("post_rst_r4", 4'd4, 32'd0);
        dbg_chk("post_rst_r10", 4'd10, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Instruction-driven sequencer that feeds the clocked ALU (funct codes ADD=1 … SRL=9) and consumes its registered result. Holds a 16 x 32 register file, accepts one instruction per valid/ready handshake, drives `a`/`b`/`shamt`/`funct` to the ALU, and writes `res` back to the register file. It reports each retired result on an output strobe. It sits between the instruction source and the ALU.

## Interface

Parameters:
- `R0_ZERO`, default 1: when 1, R0 always reads 0 and writes to it are discarded. When 0, R0 is an ordinary register.

Ports:
- `clk`  in  1  rising-edge clock, shared with the ALU.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `in_instr`  in  32  fields:
  - op[31:28]
  - rd[27:24]
  - rs[23:20]
  - rt[19:16]
  - shamt[15:11]
  - imm[15:0] (LDI only)
- `alu_a`, `alu_b`  out  32  operands R[rs], R[rt]; registered.
- `alu_shamt`  out  5  instr shamt field; registered.
- `alu_funct`  out  4  ALU function code; registered; 0 whenever not in ISSUE.
- `alu_res`  in  32  ALU registered result.
- `out_valid`  out  1  one-cycle retire strobe.
- `out_rd`  out  4  destination of retired instruction.
- `out_data`  out  32  value written (or discarded, for rd=0 with R0_ZERO=1).
- `err_illegal`  out  1  one-cycle pulse for an illegal op.
- `dbg_addr`  in  4  debug read address.
- `dbg_data`  out  32  combinational R[dbg_addr], with the R0_ZERO rule applied.

## Operation

Op decode:
- op 1–9: passed unchanged as `alu_funct` (ADD, SUB, AND, OR, XOR, NOT, SLA, SRA, SRL).
- op 10 (LDI): R[rd] <= {16'b0, imm}. The ALU is not used and `alu_funct` stays 0.
- op 0 and op 11–15: illegal.

State machine (IDLE, ISSUE, WB):
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` with a legal op: latch instr, register `alu_a`=R[rs], `alu_b`=R[rt], `alu_shamt`, and `alu_funct` (0 for LDI); go to ISSUE.
  - On `in_valid` with an illegal op: pulse `err_illegal` next cycle, stay in IDLE, no writeback, no `out_valid`.
- **ISSUE**
  - Operand outputs held stable. The ALU samples them at the closing edge.
  - `alu_funct` returns to 0 at that edge, so the ALU holds `res` thereafter. Go to WB.
- **WB**
  - At the closing edge, write `alu_res` (or imm for LDI) to R[rd], unless rd=0 with R0_ZERO=1.
  - Register `out_valid`=1, `out_rd`, `out_data`. Go to IDLE.

Other rules:
- Operands are read at accept time. Instructions are strictly serial, so there are no hazards; an instruction reading the previous rd sees the written value.
- Shift semantics (including shamt=0 using `alu_b[0]`) belong to the ALU. This unit forwards the fields untouched.

Reset:
- All registers 0 and state IDLE.
- `in_ready`=1 after reset.
- All other outputs 0.
- Reset mid-instruction aborts it: no register write, no `out_valid`.

## Timing

- E0: accepting edge.
- E1: the ALU registers `res`.
- E2: register-file write; `out_valid` is high in the cycle after E2.
- `in_ready` is high in that same cycle, so the next accept is at E3. Throughput is one instruction per 3 cycles.
- `in_ready` is low during ISSUE and WB. `in_valid` is ignored there and the source must hold.
- Illegal op: `err_illegal` is high in the cycle after E0, and `in_ready` stays high throughout. Back-to-back illegal ops produce back-to-back pulses.
- `out_valid` and `err_illegal` are never high together.
- `alu_funct` is non-zero for exactly one cycle per legal ALU op.

## Test plan

- **Reset, then NOT R1,R0.** Expected:
  - out_valid 3 cycles after accept, out_rd=1, out_data=0xFFFFFFFF.
  - dbg R1=0xFFFFFFFF.
  - alu_funct=6 for exactly one cycle.
- **LDI R2,0x0005; LDI R3,0x0003; ADD R4,R2,R3; SUB R5,R3,R2.** Expected:
  - R4=8.
  - R5=0xFFFFFFFE.
  - Each retire is spaced 3 cycles apart under continuous in_valid.
- **LDI R6,0x8000 then SLA R7,R6 shamt=16, SRA R8,R7 shamt=4, SRL R9,R7 shamt=4.** Expected:
  - R7=0x80000000.
  - R8=0xF8000000.
  - R9=0x08000000.
- **Shamt=0 path, with R2=5 and R1=0xFFFFFFFF.** SRL R10,R1,R2 shamt=0 → R10=0x7FFFFFFF (shift by R2[0]=1).
- **Illegal op 0 then op 15, then write to R0.** Expected:
  - Two err_illegal pulses, no out_valid, register file unchanged.
  - LDI R0,0x1234 → out_data=0x1234 but dbg R0=0.
- **Assert rst in the ISSUE cycle of ADD R4,R2,R3.** Expected:
  - No out_valid.
  - All registers read 0.
  - in_ready=1 on the first cycle after rst deasserts.
